jk_reg_bank: RTL

//  - WIDTH-bit bank of independent JK-style storage bits with a selectable update mode (JK / D / T / HOLD).
//  - Per-bit synchronous clear and preset; global clock enable.
//  - Registered change flag and a saturating activity counter.
//  - Next-generation replacement for the single-bit JK flip-flop; used wherever control/status flag banks need set/reset/toggle semantics.

---
 rtl/jk_reg_bank_pkg.sv | 34 +++
 rtl/jk_bank_cell.sv | 44 ++++
 rtl/jk_reg_bank.sv | 76 +++++++
 3 files changed

// File: rtl/jk_reg_bank_pkg.sv
// Shared types and the per-bit update rule for the JK register bank.
package jk_reg_bank_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_JK   = 2'd0,
        MODE_D    = 2'd1,
        MODE_T    = 2'd2,
        MODE_HOLD = 2'd3
    } mode_e;

    // Mode-driven next value of one bit (clear/preset handled by the caller).
    function automatic logic next_bit(input mode_e mode, input logic q,
                                      input logic j, input logic k);
        logic nb;
        nb = q;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b00:   nb = q;
                    2'b01:   nb = 1'b0;
                    2'b10:   nb = 1'b1;
                    default: nb = ~q;
                endcase
            end
            MODE_D:  nb = j;
            MODE_T:  nb = q ^ j;
            default: nb = q;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/jk_bank_cell.sv
// One storage bit: clear > preset > enabled mode update > hold.
module jk_bank_cell
    import jk_reg_bank_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  rst_val,
    input  logic  en,
    input  mode_e mode,
    input  logic  j,
    input  logic  k,
    input  logic  clr,
    input  logic  pre,
    output logic  q,
    output logic  q_next
);

    logic q_q;
    logic q_d;

    // Clear beats preset so a bit with both asserted goes low.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 1'b0;
        end else if (pre) begin
            q_d = 1'b1;
        end else if (en) begin
            q_d = next_bit(mode, q_q, j, k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign q_next = q_d;

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of JK-style flag bits with change flag and saturating activity counter.
module jk_reg_bank
    import jk_reg_bank_pkg::*;
#(
    parameter int unsigned           WIDTH   = 4,
    parameter logic [WIDTH-1:0]      RST_VAL = '0,
    parameter int unsigned           CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] clr,
    input  logic [WIDTH-1:0] pre,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             changed,
    output logic [CNT_W-1:0] act_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_next;
    logic             any_change;
    logic             changed_q;
    logic             changed_d;
    logic [CNT_W-1:0] act_cnt_q;
    logic [CNT_W-1:0] act_cnt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_bank_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .rst_val(RST_VAL[i]),
            .en     (en),
            .mode   (mode),
            .j      (j[i]),
            .k      (k[i]),
            .clr    (clr[i]),
            .pre    (pre[i]),
            .q      (q[i]),
            .q_next (q_next[i])
        );
    end

    assign any_change = |(q_next ^ q);

    // Counter clear wins over the increment on the same edge.
    always_comb begin
        changed_d = any_change;
        act_cnt_d = act_cnt_q;
        if (cnt_clr) begin
            act_cnt_d = '0;
        end else if (any_change && (act_cnt_q != CNT_MAX)) begin
            act_cnt_d = act_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            changed_q <= 1'b0;
            act_cnt_q <= '0;
        end else begin
            changed_q <= changed_d;
            act_cnt_q <= act_cnt_d;
        end
    end

    assign qn      = ~q;
    assign changed = changed_q;
    assign act_cnt = act_cnt_q;

endmodule
